// File: rtl/shared_resource_arb_n.sv
// N-channel front end: per-channel skid FIFOs, a round-robin arbiter and one shared
// combinational resource whose results land in per-channel output registers.
module shared_resource_arb_n #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_flush,
    input  logic [NUM_CH-1:0]        in_stall,
    output logic [NUM_CH-1:0]        out_stall,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        out_flush,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        grant
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RR_W  = $clog2(NUM_CH);

    // Shared resource: multiply by three, truncated to DATA_W.
    function automatic logic [DATA_W-1:0] shared_resource(input logic [DATA_W-1:0] x);
        return x + {x[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_W-1:0]        mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]         rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]         count_q  [NUM_CH];
    logic [RR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]        out_valid_q, out_flush_q;
    logic [NUM_CH*DATA_W-1:0] out_data_q;

    logic [NUM_CH-1:0] empty, full, req, enq, deq;
    logic [DATA_W-1:0] head [NUM_CH];
    logic [RR_W-1:0]   idx;
    logic              found;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i] = (count_q[i] == '0);
            full[i]  = (count_q[i] == CNT_W'(DEPTH));
            head[i]  = empty[i] ? in_data[i*DATA_W +: DATA_W] : mem_q[i][rd_ptr_q[i]];
            req[i]   = (in_valid[i] | ~empty[i]) & ~(in_stall[i] & out_valid_q[i])
                       & ~in_flush[i];
        end
    end

    // Scan from rr_ptr upward; the first requester wins and the pointer moves past it.
    always_comb begin
        grant    = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = '0;
        if (!reset) begin
            for (int unsigned off = 0; off < NUM_CH; off++) begin
                idx = RR_W'((32'(rr_ptr_q) + off) % NUM_CH);
                if (!found && req[idx]) begin
                    found     = 1'b1;
                    grant[idx] = 1'b1;
                    rr_ptr_d  = RR_W'((32'(idx) + 1) % NUM_CH);
                end
            end
        end
    end

    // A word bypassed straight into the resource is never also written to the FIFO.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            deq[i] = grant[i] & ~empty[i];
            enq[i] = in_valid[i] & ~full[i] & ~(grant[i] & empty[i]) & ~in_flush[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (enq[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= '0;
            out_flush_q <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_flush[i]) begin
                    wr_ptr_q[i]    <= '0;
                    rd_ptr_q[i]    <= '0;
                    count_q[i]     <= '0;
                    out_valid_q[i] <= 1'b0;
                    out_flush_q[i] <= 1'b1;
                end else begin
                    out_flush_q[i] <= 1'b0;
                    if (grant[i]) begin
                        out_data_q[i*DATA_W +: DATA_W] <= shared_resource(head[i]);
                        out_valid_q[i]                 <= 1'b1;
                    end else if (!(out_valid_q[i] && in_stall[i])) begin
                        out_valid_q[i] <= 1'b0;
                    end
                    if (enq[i]) begin
                        wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                    end
                    if (deq[i]) begin
                        rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                    end
                    if (enq[i] && !deq[i]) begin
                        count_q[i] <= count_q[i] + CNT_W'(1);
                    end else if (deq[i] && !enq[i]) begin
                        count_q[i] <= count_q[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_stall = full;
    assign out_valid = out_valid_q;
    assign out_flush = out_flush_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_shared_resource_arb_n.sv
// Directed bench for shared_resource_arb_n (4 channels, 32-bit, depth 4); the
// resource is modelled as x*3 mod 2^32.
module tb_shared_resource_arb_n;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_valid, in_flush, in_stall;
    logic [3:0]   out_stall, out_valid, out_flush, grant;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] n;
        logic [3:0]  g;
        logic [3:0]  stall;
        logic [3:0]  v;
        logic [31:0] word;
    } vec_t;

    vec_t vec [6];

    shared_resource_arb_n #(
        .NUM_CH(4),
        .DATA_W(32),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_flush (in_flush),
        .in_stall (in_stall),
        .out_stall(out_stall),
        .out_valid(out_valid),
        .out_flush(out_flush),
        .out_data (out_data),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] x);
        return x * 32'd3;
    endfunction

    function automatic logic [31:0] od(input int c);
        return out_data[c*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic [31:0] d);
        in_valid[c]          = v;
        in_data[c*32 +: 32]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          p;
        int          expw;
        int          ch;
        logic        g;
        logic        acc;
        logic [127:0] e;

        // Round-robin stream, starting with ptr=3 and all FIFOs empty.
        vec[0] = '{n: 0, g: 4'b1000, stall: 4'b0000, v: 4'b1000, word: 32'h400};
        vec[1] = '{n: 1, g: 4'b0001, stall: 4'b0000, v: 4'b0001, word: 32'h100};
        vec[2] = '{n: 2, g: 4'b0010, stall: 4'b0000, v: 4'b0010, word: 32'h200};
        vec[3] = '{n: 3, g: 4'b0100, stall: 4'b0000, v: 4'b0100, word: 32'h300};
        vec[4] = '{n: 4, g: 4'b1000, stall: 4'b0000, v: 4'b1000, word: 32'h401};
        vec[5] = '{n: 5, g: 4'b0001, stall: 4'b0111, v: 4'b0001, word: 32'h101};

        reset    = 1'b1;
        in_valid = 4'hF;
        in_flush = '0;
        in_stall = '0;
        in_data  = '0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_out_flush", out_flush, 4'h0);
        check("rst_out_stall", out_stall, 4'h0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_grant", grant, 4'h0);
        in_valid = '0;
        reset    = 1'b0;
        tick();

        // Only ch2 requests: granted from ptr=0, then again from ptr=3.
        drive(2, 1'b1, 32'h55);
        #1 check("t6_grant_first", grant, 4'b0100);
        tick();
        check("t6_valid_first", out_valid, 4'b0100);
        check("t6_data_first", od(2), f(32'h55));
        drive(2, 1'b1, 32'h66);
        #1 check("t6_grant_ptr3", grant, 4'b0100);
        tick();
        check("t6_valid_ptr3", out_valid, 4'b0100);
        check("t6_data_ptr3", od(2), f(32'h66));

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(c, 1'b1, 32'(32'h100 * (c + 1)) + vec[r].n);
            end
            #1;
            check($sformatf("rr_grant_%0d", r), grant, vec[r].g);
            check($sformatf("rr_stall_%0d", r), out_stall, vec[r].stall);
            tick();
            ch = 0;
            for (int c = 0; c < 4; c++) begin
                if (vec[r].g[c]) ch = c;
            end
            check($sformatf("rr_valid_%0d", r), out_valid, vec[r].v);
            check($sformatf("rr_data_%0d", r), od(ch), f(vec[r].word));
        end

        // Reset asserted mid-stream clears everything immediately.
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 4'h0);
        check("mid_rst_stall", out_stall, 4'h0);
        check("mid_rst_grant", grant, 4'h0);
        check("mid_rst_data", out_data, 128'h0);
        tick();
        in_valid = '0;
        reset    = 1'b0;
        tick();

        drive(0, 1'b1, 32'h11);
        #1 check("t1_grant", grant, 4'b0001);
        tick();
        e        = '0;
        e[31:0]  = f(32'h11);
        check("t1_valid", out_valid, 4'b0001);
        check("t1_data", out_data, e);
        check("t1_flush", out_flush, 4'h0);
        check("t1_stall", out_stall, 4'h0);
        in_valid = '0;
        tick();
        check("t1_valid_drop", out_valid, 4'h0);

        // ch1 stalled while streaming 1..6, then released.
        p    = 1;
        expw = 1;
        for (int cyc = 0; cyc < 30 && expw <= 6; cyc++) begin
            in_stall[1] = (cyc < 6);
            drive(1, p <= 6, 32'(p));
            #1;
            g   = grant[1];
            acc = in_valid[1] & ~out_stall[1];
            tick();
            if (acc) p++;
            if (g) begin
                check($sformatf("t3_order_%0d", expw), od(1), f(32'(expw)));
                expw++;
            end
            if (cyc == 4) begin
                check("t3_full_stall", out_stall, 4'b0010);
                check("t3_valid_held", out_valid[1], 1'b1);
                check("t3_data_held", od(1), f(32'h1));
            end
        end
        check("t3_delivered", expw, 7);
        check("t3_accepted", p, 7);
        in_valid = '0;
        in_stall = '0;
        tick();

        // ch2 holds three words, flushed while ch3/ch0 keep flowing.
        drive(2, 1'b1, 32'h21);
        #1 check("t4_grant_first", grant, 4'b0100);
        tick();
        in_stall[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(2, 1'b1, 32'h22 + 32'(k));
            #1 check($sformatf("t4_blocked_%0d", k), grant, 4'h0);
            tick();
        end
        check("t4_held_valid", out_valid[2], 1'b1);
        check("t4_held_data", od(2), f(32'h21));
        in_stall[2] = 1'b0;
        in_flush[2] = 1'b1;
        drive(2, 1'b1, 32'h25);
        drive(3, 1'b1, 32'h31);
        drive(0, 1'b1, 32'h01);
        #1 check("t4_flush_grant", grant, 4'b1000);
        tick();
        check("t4_out_flush", out_flush, 4'b0100);
        check("t4_valid", out_valid, 4'b1000);
        check("t4_ch3_data", od(3), f(32'h31));
        in_flush[2] = 1'b0;
        drive(2, 1'b0, 32'h0);
        drive(3, 1'b0, 32'h0);
        drive(0, 1'b1, 32'h02);
        #1 check("t4_ch0_grant", grant, 4'b0001);
        tick();
        check("t4_flush_pulse", out_flush, 4'h0);
        check("t4_ch0_valid", out_valid, 4'b0001);
        check("t4_ch0_data", od(0), f(32'h01));
        drive(0, 1'b0, 32'h0);
        drive(2, 1'b1, 32'h26);
        #1 check("t4_ch2_grant", grant, 4'b0100);
        tick();
        check("t4_ch2_empty_bypass", od(2), f(32'h26));
        drive(2, 1'b0, 32'h0);
        #1 check("t4_ch0_second_grant", grant, 4'b0001);
        tick();
        check("t4_ch0_second_data", od(0), f(32'h02));

        // ch3 full, fire and in_valid in the same cycle.
        in_stall[3] = 1'b1;
        drive(3, 1'b1, 32'h40);
        #1 check("t5_grant_first", grant, 4'b1000);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(3, 1'b1, 32'h41 + 32'(k));
            tick();
        end
        check("t5_full", out_stall, 4'b1000);
        in_stall[3] = 1'b0;
        drive(3, 1'b1, 32'h45);
        #1;
        check("t5_full_pre", out_stall, 4'b1000);
        check("t5_fire_full", grant, 4'b1000);
        tick();
        check("t5_deq_data", od(3), f(32'h41));
        check("t5_stall_drop", out_stall, 4'h0);
        #1 check("t5_grant_accept", grant, 4'b1000);
        tick();
        check("t5_data_2", od(3), f(32'h42));
        check("t5_stall_after", out_stall, 4'h0);
        drive(3, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t5_drain_%0d", k), od(3), f(32'h43 + 32'(k)));
        end
        #1 check("t5_empty_grant", grant, 4'h0);
        tick();
        check("t5_valid_drop", out_valid, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
